// File: rtl/fifo_pkg.sv
// ============================================================================
// Module : fifo_pkg
// Brief  : Default widths and Gray-code helper shared by the FIFO core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    // Callers truncate the result to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
        return i_bin ^ (i_bin >> 1);
    endfunction
endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-stage flop chain with synchronous reset for pointer crossing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

`default_nettype wire

// File: rtl/fifo_async_core.sv
// ============================================================================
// Module : fifo_async_core
// Brief  : Single-clock FIFO using Gray pointers and 2-flop synchronizers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_async_core
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);
    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic [ADDR_WIDTH:0]   r_wr_bin;
    logic [ADDR_WIDTH:0]   r_wr_gray;
    logic [ADDR_WIDTH:0]   r_rd_bin;
    logic [ADDR_WIDTH:0]   r_rd_gray;
    logic [ADDR_WIDTH:0]   w_wq2_wr_gray;
    logic [ADDR_WIDTH:0]   w_rq2_rd_gray;
    logic [ADDR_WIDTH:0]   w_wr_bin_next;
    logic [ADDR_WIDTH:0]   w_rd_bin_next;
    logic [ADDR_WIDTH:0]   w_wr_gray_next;
    logic [ADDR_WIDTH:0]   w_rd_gray_next;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    assign w_wr_acc       = wr_en && !full;
    assign w_rd_acc       = rd_en && !empty;
    assign w_wr_bin_next  = r_wr_bin + 1'b1;
    assign w_rd_bin_next  = r_rd_bin + 1'b1;
    assign w_wr_gray_next = (ADDR_WIDTH+1)'(bin2gray(32'(w_wr_bin_next)));
    assign w_rd_gray_next = (ADDR_WIDTH+1)'(bin2gray(32'(w_rd_bin_next)));

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_bin[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
        end else if (w_wr_acc) begin
            r_wr_bin  <= w_wr_bin_next;
            r_wr_gray <= w_wr_gray_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
            r_rd_data <= '0;
        end else if (w_rd_acc) begin
            r_rd_bin  <= w_rd_bin_next;
            r_rd_gray <= w_rd_gray_next;
            r_rd_data <= r_mem[r_rd_bin[ADDR_WIDTH-1:0]];
        end
    end

    sync_2ff #(.WIDTH(ADDR_WIDTH+1)) u_sync_wr (
        .clk (clk),
        .rst (rst),
        .i_d (r_wr_gray),
        .o_q (w_wq2_wr_gray)
    );

    sync_2ff #(.WIDTH(ADDR_WIDTH+1)) u_sync_rd (
        .clk (clk),
        .rst (rst),
        .i_d (r_rd_gray),
        .o_q (w_rq2_rd_gray)
    );

    // In Gray code a full lap differs from the read pointer in the top two bits.
    assign empty   = (r_rd_gray == w_wq2_wr_gray);
    assign full    = (r_wr_gray == {~w_rq2_rd_gray[ADDR_WIDTH:ADDR_WIDTH-1],
                                     w_rq2_rd_gray[ADDR_WIDTH-2:0]});
    assign rd_data = r_rd_data;
endmodule

`default_nettype wire

// File: tb/tb_fifo_async_core.sv
// ============================================================================
// Module : tb_fifo_async_core
// Brief  : Randomized scoreboard bench for fifo_async_core (16 x 8 default).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_async_core;
    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;

    fifo_async_core dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word queue plus accepted-write/read totals with history,
    // since each flag sees the other side's count two edges late.
    logic [7:0] model_q[$];
    logic [7:0] exp_q[$];
    int  tot_w = 0, tot_r = 0;
    int  wh[3] = '{0, 0, 0};
    int  rh[3] = '{0, 0, 0};
    logic m_empty = 1'b1;
    logic m_full  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic rs);
        logic acc_w, acc_r;
        @(negedge clk);
        rst = rs; wr_en = we; wr_data = wd; rd_en = re;
        acc_r = re && !rs && !m_empty;
        acc_w = we && !rs && !m_full;
        if (acc_r) exp_q.push_back(model_q.pop_front());
        if (acc_w) model_q.push_back(wd);
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            tot_w = 0; tot_r = 0;
            wh = '{0, 0, 0}; rh = '{0, 0, 0};
        end else begin
            tot_w += int'(acc_w);
            tot_r += int'(acc_r);
        end
        wh[2] = wh[1]; wh[1] = wh[0]; wh[0] = tot_w;
        rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = tot_r;
        m_empty = (tot_r == wh[2]);
        m_full  = ((tot_w - rh[2]) == 16);
        #1;
        chk("empty", 32'(empty), 32'(m_empty));
        chk("full",  32'(full),  32'(m_full));
    endtask

    // Monitor: a read handshake at an edge presents a word right after it.
    initial begin : monitor
        logic       fire, r_seen;
        logic [7:0] last, e;
        last = 8'h00;
        forever begin
            @(posedge clk);
            fire   = !rst && rd_en && !empty;
            r_seen = rst;
            #1;
            if (r_seen) begin
                last = 8'h00;
                chk("rd_data_reset", 32'(rd_data), 32'h0);
            end else if (fire) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_read: got %0h expected no read", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e));
                    last = e;
                end
            end else begin
                chk("rd_data_hold", 32'(rd_data), 32'(last));
            end
        end
    end

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin : stim
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;

        do_reset(3);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full",  32'(full),  32'h0);

        // Single word visibility and read-back.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        idle(3);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Fill, attempted overflow, drain in order.
        do_reset(3);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'h1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        drain(20);

        // Full release two edges after the freeing read.
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h10, 1'b0, 1'b0);
        drain(20);

        // Concurrent traffic with 8 resident words, crossing pointer wrap.
        do_reset(2);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        idle(3);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8 + i), 1'b1, 1'b0);
        drain(12);

        // Reset mid-traffic discards everything.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        do_reset(3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic gated by the DUT's own flags, alternating bias.
        for (int i = 0; i < 10000; i++) begin
            logic we, re;
            int   wp;
            wp = ((i / 500) % 2 == 0) ? 70 : 30;
            we = ($urandom_range(0, 99) < wp) && !full;
            re = ($urandom_range(0, 99) < (100 - wp)) && !empty;
            cycle(we, 8'($urandom), re, 1'b0);
        end
        drain(24);
        idle(2);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("model_drained", 32'(model_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
